// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the byte-serial AES-128 engine.
package aes_pkg;

    typedef enum logic [1:0] {
        C_ID = 2'b00,
        C_SP = 2'b01,
        C_SK = 2'b10,
        C_ST = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ROUND  = 2'b01,
        S_OUTPUT = 2'b10
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [3:0] LAST_IDX   = 4'd15;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1B;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; column c, row r is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    // a^254 equals a^-1 for nonzero a and maps 0 to 0, matching the S-box definition.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] inv_s;

    assign inv_s = gf_inv(a_i);
    assign s_o   = inv_s
                 ^ {inv_s[6:0], inv_s[7]}
                 ^ {inv_s[5:0], inv_s[7:6]}
                 ^ {inv_s[4:0], inv_s[7:5]}
                 ^ {inv_s[3:0], inv_s[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_engine.sv
// Byte-serial AES-128 encryptor: byte loads, one round per clock, 16-byte registered output stream.
module aes_engine
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] din,
    input  logic [1:0] cmd,
    output logic       interface_ready,
    output logic [7:0] dout,
    output logic       data_ok
);

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   dout_q, dout_d;
    logic         ok_q, ok_d;
    logic         rdy_q, rdy_d;

    logic [127:0] sub_s, sr_s, mc_s, nk_s, round_out_s;
    logic [31:0]  rot_s, ksub_s, temp_s;
    logic [31:0]  nk0_s, nk1_s, nk2_s, nk3_s;
    logic [7:0]   out_byte_s;

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_state_sbox
            aes_sbox u_sbox (
                .a_i (st_q[127 - 8*g -: 8]),
                .s_o (sub_s[127 - 8*g -: 8])
            );
        end
        for (g = 0; g < 4; g++) begin : g_key_sbox
            aes_sbox u_sbox (
                .a_i (rot_s[31 - 8*g -: 8]),
                .s_o (ksub_s[31 - 8*g -: 8])
            );
        end
    endgenerate

    // Next round key is derived from the current one, so only one 128-bit key register is needed.
    assign rot_s  = {rk_q[23:0], rk_q[31:24]};
    assign temp_s = ksub_s ^ {rcon(round_q), 24'h000000};
    assign nk0_s  = rk_q[127:96] ^ temp_s;
    assign nk1_s  = rk_q[95:64] ^ nk0_s;
    assign nk2_s  = rk_q[63:32] ^ nk1_s;
    assign nk3_s  = rk_q[31:0] ^ nk2_s;
    assign nk_s   = {nk0_s, nk1_s, nk2_s, nk3_s};

    assign sr_s        = shift_rows(sub_s);
    assign mc_s        = {mix_column(sr_s[127:96]), mix_column(sr_s[95:64]),
                          mix_column(sr_s[63:32]), mix_column(sr_s[31:0])};
    assign round_out_s = ((round_q == LAST_ROUND) ? sr_s : mc_s) ^ nk_s;
    assign out_byte_s  = st_q[(7'd127 - {idx_q, 3'b000}) -: 8];

    // Command decode, FSM sequencing and datapath next-state selection.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        pt_d    = pt_q;
        key_d   = key_q;
        st_d    = st_q;
        rk_d    = rk_q;
        dout_d  = dout_q;
        ok_d    = 1'b0;
        rdy_d   = rdy_q;

        if (rdy_q && (cmd == C_SP)) begin
            pt_d = {pt_q[119:0], din};
        end else begin
            pt_d = pt_q;
        end

        if (rdy_q && (cmd == C_SK)) begin
            key_d = {key_q[119:0], din};
        end else begin
            key_d = key_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rdy_q && (cmd == C_ST)) begin
                    st_d    = pt_q ^ key_q;
                    rk_d    = key_q;
                    round_d = 4'd1;
                    rdy_d   = 1'b0;
                    state_d = S_ROUND;
                end else begin
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ROUND: begin
                st_d  = round_out_s;
                rk_d  = nk_s;
                rdy_d = 1'b0;
                if (round_q == LAST_ROUND) begin
                    idx_d   = 4'd0;
                    state_d = S_OUTPUT;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_OUTPUT: begin
                rdy_d  = 1'b1;
                ok_d   = 1'b1;
                dout_d = out_byte_s;
                idx_d  = idx_q + 4'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, load, working and output registers.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            idx_q   <= 4'd0;
            pt_q    <= 128'h0;
            key_q   <= 128'h0;
            st_q    <= 128'h0;
            rk_q    <= 128'h0;
            dout_q  <= 8'h00;
            ok_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            dout_q  <= dout_d;
            ok_q    <= ok_d;
            rdy_q   <= rdy_d;
        end
    end

    assign interface_ready = rdy_q;
    assign dout            = dout_q;
    assign data_ok         = ok_q;

endmodule

// File: tb/tb_aes_engine.sv
// Scoreboard bench for aes_engine: reference AES model, known vectors, random blocks and protocol cases.
module tb_aes_engine;

    localparam logic [1:0] K_ID = 2'b00;
    localparam logic [1:0] K_SP = 2'b01;
    localparam logic [1:0] K_SK = 2'b10;
    localparam logic [1:0] K_ST = 2'b11;

    logic       clk;
    logic       rst_;
    logic [7:0] din;
    logic [1:0] cmd;
    logic       interface_ready;
    logic [7:0] dout;
    logic       data_ok;

    aes_engine dut (
        .clk             (clk),
        .rst_            (rst_),
        .din             (din),
        .cmd             (cmd),
        .interface_ready (interface_ready),
        .dout            (dout),
        .data_ok         (data_ok)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int blk_cnt = 0;
    logic [7:0] exp_q[$];
    int lat_q[$];
    logic [7:0] sb[256];
    logic [127:0] pt_m = 128'h0;
    logic [127:0] key_m = 128'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    // S-box table from the classic generator/inverse walk of GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] w[176];
        logic [7:0] tmp[4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127 - 8*i -: 8];
            w[i] = key[127 - 8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                a0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[a0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = sb[s[4*((c + row) % 4) + row]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c + 1]; a2 = t[4*c + 2]; a3 = t[4*c + 3];
                if (r < 10) begin
                    s[4*c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c + 1] = a1; s[4*c + 2] = a2; s[4*c + 3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        cmd = c;
        din = d;
        tick();
        if (c == K_SP) pt_m = {pt_m[119:0], d};
        if (c == K_SK) key_m = {key_m[119:0], d};
    endtask

    task automatic load(input logic [1:0] c, input logic [127:0] v);
        for (int i = 0; i < 16; i++) send(c, v[127 - 8*i -: 8]);
        cmd = K_ID;
    endtask

    task automatic rand_block(output logic [127:0] v);
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic start_block(input logic [127:0] expv);
        cmd = K_ST;
        din = 8'($urandom());
        tick();
        lat_q.push_back(edge_cnt + 11);
        for (int i = 0; i < 16; i++) exp_q.push_back(expv[127 - 8*i -: 8]);
        cmd = K_ID;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || data_ok) && guard < 80) begin
            tick();
            guard++;
        end
        chk("drain_remaining", 128'(exp_q.size()), 128'd0);
        tick();
    endtask

    // Runs one encryption; noise drives random commands during rounds, reload loads new_pt during output.
    task automatic run_block(input logic [127:0] expv, input bit noise, input bit reload, input logic [127:0] new_pt);
        start_block(expv);
        chk("ready_low_after_start", 128'(interface_ready), 128'd0);
        for (int k = 1; k <= 10; k++) begin
            if (noise) begin
                cmd = 2'($urandom_range(1, 3));
                din = 8'($urandom());
            end else begin
                cmd = K_ID;
            end
            tick();
            chk("ready_low_in_rounds", 128'(interface_ready), 128'd0);
        end
        cmd = K_ID;
        tick();
        chk("ready_high_in_output", 128'(interface_ready), 128'd1);
        if (reload) load(K_SP, new_pt);
        cmd = K_ID;
        wait_drain();
    endtask

    // Monitor: compares each streamed byte and the first-byte latency against the scoreboard.
    initial begin
        logic [7:0] e;
        int l;
        forever begin
            @(negedge clk);
            if (rst_) begin
                blk_cnt = 0;
            end else if (data_ok) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected no data_ok", dout);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        n_err++;
                        $display("FAIL cipher_byte%0d: got %0h expected %0h", blk_cnt, dout, e);
                    end
                end
                if (blk_cnt == 0 && lat_q.size() != 0) begin
                    l = lat_q.pop_front();
                    n_vec++;
                    if (edge_cnt != l) begin
                        n_err++;
                        $display("FAIL first_byte_edge: got %0d expected %0d", edge_cnt, l);
                    end
                end
                blk_cnt = (blk_cnt == 15) ? 0 : blk_cnt + 1;
            end
        end
    end

    initial begin
        logic [127:0] a, b, c;
        int guard;
        build_sbox();
        rst_ = 1'b0;
        cmd  = K_ID;
        din  = 8'h00;
        #2 rst_ = 1'b1;
        #10;
        chk("reset_dout", 128'(dout), 128'd0);
        chk("reset_data_ok", 128'(data_ok), 128'd0);
        chk("reset_ready", 128'(interface_ready), 128'd1);
        @(negedge clk);
        rst_ = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("idle_dout", 128'(dout), 128'd0);
            chk("idle_data_ok", 128'(data_ok), 128'd0);
            chk("idle_ready", 128'(interface_ready), 128'd1);
            tick();
        end

        load(K_SP, 128'h00041214120412000C00131108231919);
        load(K_SK, 128'h2475A2B33475568831E2120013AA5487);
        run_block(128'hBC028BD3E0E3B195550D6DF8E6F18241, 1'b0, 1'b0, 128'h0);

        load(K_SP, 128'h00112233445566778899AABBCCDDEEFF);
        load(K_SK, 128'h000102030405060708090A0B0C0D0E0F);
        run_block(128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b0, 1'b0, 128'h0);

        for (int i = 0; i < 2; i++) begin
            rand_block(a);
            rand_block(b);
            load(K_SP, a);
            load(K_SK, b);
            run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b0, 128'h0);
        end

        rand_block(a);
        rand_block(b);
        load(K_SP, a);
        load(K_SK, b);
        run_block(ref_encrypt(pt_m, key_m), 1'b1, 1'b0, 128'h0);
        run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b0, 128'h0);

        rand_block(a);
        rand_block(c);
        run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b1, c);
        run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b0, 128'h0);

        for (int i = 0; i < 20; i++) send(K_SP, 8'($urandom()));
        cmd = K_ID;
        run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b0, 128'h0);

        rand_block(a);
        load(K_SP, a);
        start_block(ref_encrypt(pt_m, key_m));
        guard = 0;
        while (blk_cnt < 5 && guard < 60) begin
            tick();
            guard++;
        end
        chk("reached_byte5", 128'(blk_cnt), 128'd5);
        #2 rst_ = 1'b1;
        #1;
        chk("abort_data_ok", 128'(data_ok), 128'd0);
        chk("abort_ready", 128'(interface_ready), 128'd1);
        chk("abort_dout", 128'(dout), 128'd0);
        exp_q.delete();
        lat_q.delete();
        pt_m  = 128'h0;
        key_m = 128'h0;
        @(negedge clk);
        rst_ = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("post_abort_quiet", 128'(data_ok), 128'd0);
            tick();
        end
        run_block(ref_encrypt(pt_m, key_m), 1'b0, 1'b0, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
